shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit combinational shifter.
- Performs logical left, logical right, arithmetic right, rotate-left and rotate-right shifts on a WIDTH-bit operand.
- Uses log2(WIDTH) registered stages with valid/ready handshakes on input and output.
- Sits between the register-file read port and the ALU writeback mux in the datapath; accepts one operation per clock when not stalled.

Parameters:
- WIDTH, 32, operand width; power of two, 4 to 64 inclusive.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation presented on in_* this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  unsigned shift amount, 0..WIDTH-1.
- in_mode  input  3  000/001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 reserved (pass-through).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Stages: S = SHAMT_W stages, ordered largest shift first. Stage j shifts by 2^(S-1-j) when shamt bit (S-1-j) is 1, otherwise passes through. Each stage has a pipeline register holding valid, data, shamt and mode.
- Shift fill rules:
  - LSL: zero-fill from the LSB.
  - LSR: zero-fill from the MSB.
  - ASR: MSB replicated, taken from that stage's input.
  - ROL/ROR: wrap bits around.
  - Reserved modes: data unchanged at every stage.
- Latency: exactly S cycles from the in_valid && in_ready edge to out_valid, with no stall. Throughput is 1 op/cycle.
- Global advance enable: adv = out_ready || !out_valid.
  - in_ready = adv (combinational).
  - All stage registers load only when adv = 1.
  - When adv = 0, every stage holds its contents; bubbles do not collapse.
- Stage-0 valid loads in_valid && in_ready; later stages load the previous stage's valid.
- out_valid and out_data are the last stage's registers. out_data stays stable while out_valid && !out_ready.
- Shift by 0: output equals input for all modes.
- Reset value of every output:
  - rst_n = 0 at an edge clears all stage valids, data, shamt and mode to 0.
  - Thus out_valid = 0 and out_data = 0; in_ready = 1 after reset, since out_valid = 0.
- Reset mid-operation: all in-flight operations are discarded, with no partial results.
- Simultaneous accept while out_ready = 1 and the pipe is full: the output retires and a new op enters in the same cycle, with no lost or duplicated op.
- in_data and in_shamt are don't-care when in_valid = 0, but are still registered with valid = 0.
- Ordering: results leave in issue order.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined, adds two output ports:
  - out_zero  output  1: out_data == 0.
  - out_carry  output  1: last bit shifted or rotated out.
- Carry tracking: carry is tracked per stage. A shifting stage sets carry to the last bit it shifts out. A non-shifting stage keeps the carry unchanged. Carry starts at 0 in stage 0's input.
  - LSL: carry = in_data[WIDTH-shamt].
  - LSR/ASR: carry = in_data[shamt-1].
  - ROL: carry = result LSB. ROR: carry = result MSB.
  - shamt = 0: carry = 0. Reserved modes: carry = 0.
- Both flags are registered alongside the data, follow the same stall and reset rules, and reset to 0.
- When not defined, the ports and logic are absent; core behaviour is identical.

Test Plan (WIDTH = 32):
- LSL 0x0000_0001 shamt 31, out_ready = 1 -> out_valid exactly 5 cycles later, out_data 0x8000_0000.
- ASR 0x8000_0000 shamt 4 -> 0xF800_0000; LSR same operand and shamt -> 0x0800_0000; ROR 0x0000_00FF shamt 8 -> 0xFF00_0000; ROL 0x8000_0001 shamt 1 -> 0x0000_0003.
- Back-to-back stream of 8 ops (LSL 0x1 by 0..7) with out_ready low for cycles 6-8 -> in_ready low during the stall, out_data held stable, results 0x1,0x2,...,0x80 in order, none lost or duplicated.
- rst_n low for 1 cycle with 3 ops in flight -> out_valid = 0 and out_data = 0 the next cycle; no stale result ever appears; a new op issued after reset completes in 5 cycles.
- Mode 110 with 0x1234_5678 shamt 13 -> 0x1234_5678 (pass-through); any mode with shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- With SHIFTER_FLAGS_EN:
  - LSR 0x0000_0003 shamt 1 -> data 0x1, carry 1, zero 0.
  - LSL 0x8000_0000 shamt 1 -> data 0x0, carry 1, zero 1.
  - LSL 0x1 shamt 0 -> carry 0.

Source files
------------

// File: rtl/shifter_pipe.sv
// ---------------------------------------------------------------------------
// shifter_pipe -- pipelined barrel shifter, one stage per shift-amount bit.
//
// Modes (in_mode): 000/001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR,
//                  110/111 pass-through.
// Stages are ordered largest shift first. Stage j shifts by 2^(S-1-j) when
// shamt bit (S-1-j) is set. All stages share one advance enable, so a stall
// freezes the whole pipe and bubbles do not collapse.
//
// Optional feature macro: SHIFTER_FLAGS_EN (adds out_zero / out_carry).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operation presented this cycle
//   in_ready   out  operation accepted this cycle (= advance enable)
//   in_data    in   WIDTH-bit operand
//   in_shamt   in   shift amount 0..WIDTH-1
//   in_mode    in   3-bit shift mode
//   out_valid  out  result valid (last stage register)
//   out_ready  in   downstream accepts result
//   out_data   out  shifted result (last stage register)
//   out_zero   out  [SHIFTER_FLAGS_EN] out_data == 0
//   out_carry  out  [SHIFTER_FLAGS_EN] last bit shifted/rotated out
// ---------------------------------------------------------------------------

// One pipeline stage: conditional shift by 2^SBIT, then register.
//   i_adv   load enable shared by all stages
//   i_*     previous stage (or input port) contents
//   o_*     this stage's registers
module shifter_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int SBIT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_adv,
  input  logic               i_vld,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [2:0]         i_mode,
`ifdef SHIFTER_FLAGS_EN
  input  logic               i_carry,
  output logic               o_carry,
`endif
  output logic               o_vld,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [2:0]         o_mode
);
  localparam int AMT = 1 << SBIT;

  logic [WIDTH-1:0] w_data;

  always_comb begin
    w_data = i_data;
    if (i_shamt[SBIT]) begin
      case (i_mode)
        3'b000, 3'b001: w_data = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
        3'b010:         w_data = {{AMT{1'b0}}, i_data[WIDTH-1:AMT]};
        3'b011:         w_data = {{AMT{i_data[WIDTH-1]}}, i_data[WIDTH-1:AMT]};
        3'b100:         w_data = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
        3'b101:         w_data = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
        default:        w_data = i_data;
      endcase
    end
  end

`ifdef SHIFTER_FLAGS_EN
  // Carry is the last bit this stage pushes out; a non-shifting stage (or a
  // reserved mode) leaves the incoming carry alone. For rotates that bit is
  // also the new LSB (ROL) or MSB (ROR) of the result.
  logic w_carry;
  always_comb begin
    w_carry = i_carry;
    if (i_shamt[SBIT]) begin
      case (i_mode)
        3'b000, 3'b001, 3'b100: w_carry = i_data[WIDTH-AMT];
        3'b010, 3'b011, 3'b101: w_carry = i_data[AMT-1];
        default:                w_carry = i_carry;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_vld   <= 1'b0;
      o_data  <= '0;
      o_shamt <= '0;
      o_mode  <= '0;
`ifdef SHIFTER_FLAGS_EN
      o_carry <= 1'b0;
`endif
    end else if (i_adv) begin
      o_vld   <= i_vld;
      o_data  <= w_data;
      o_shamt <= i_shamt;
      o_mode  <= i_mode;
`ifdef SHIFTER_FLAGS_EN
      o_carry <= w_carry;
`endif
    end
  end
endmodule

module shifter_pipe #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SHIFTER_FLAGS_EN
  output logic               out_zero,
  output logic               out_carry,
`endif
  output logic [WIDTH-1:0]   out_data
);
  localparam int S = SHAMT_W;

  logic                            w_adv;
  // Index 0 is the input port, index j+1 is stage j's register.
  logic [S:0]                      vld_pipe;
  logic [S:0][WIDTH-1:0]           w_data;
  logic [S:0][SHAMT_W-1:0]         w_shamt;
  logic [S:0][2:0]                 w_mode;
`ifdef SHIFTER_FLAGS_EN
  logic [S:0]                      w_carry;
  assign w_carry[0] = 1'b0;
`endif

  // Whole pipe moves together: advance whenever the output slot is free
  // or being drained this cycle.
  assign w_adv       = out_ready || !out_valid;
  assign in_ready    = w_adv;
  assign vld_pipe[0] = in_valid && w_adv;
  assign w_data[0]   = in_data;
  assign w_shamt[0]  = in_shamt;
  assign w_mode[0]   = in_mode;

  for (genvar j = 0; j < S; j++) begin : g_stg
    shifter_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .SBIT    (S-1-j)
    ) u_stg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_vld   (vld_pipe[j]),
      .i_data  (w_data[j]),
      .i_shamt (w_shamt[j]),
      .i_mode  (w_mode[j]),
`ifdef SHIFTER_FLAGS_EN
      .i_carry (w_carry[j]),
      .o_carry (w_carry[j+1]),
`endif
      .o_vld   (vld_pipe[j+1]),
      .o_data  (w_data[j+1]),
      .o_shamt (w_shamt[j+1]),
      .o_mode  (w_mode[j+1])
    );
  end

  // Last stage's shamt/mode registers have no consumer.
  logic w_unused;
  assign w_unused = ^{w_shamt[S], w_mode[S]};

  assign out_valid = vld_pipe[S];
  assign out_data  = w_data[S];
`ifdef SHIFTER_FLAGS_EN
  // Zero is a pure function of the registered result, so it already
  // follows the same stall/reset behaviour as out_data.
  assign out_zero  = (w_data[S] == '0);
  assign out_carry = w_carry[S];
`endif
endmodule

// File: tb/tb_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_shifter_pipe -- directed + randomized checks of shifter_pipe (WIDTH=32).
// A scoreboard fed by a plain-arithmetic reference model checks every result
// leaving the pipe; directed sequences check latency, stall, reset behaviour.
// ---------------------------------------------------------------------------
module tb_shifter_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_shamt;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef SHIFTER_FLAGS_EN
  logic          out_zero;
  logic          out_carry;
`endif

  shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFTER_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_ret = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the mode definitions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s,
                                             input logic [2:0] m);
    logic signed [W-1:0] sd;
    sd = d;
    case (m)
      3'd0, 3'd1: return d << s;
      3'd2:       return d >> s;
      3'd3:       return sd >>> s;
      3'd4:       return (s == 0) ? d : ((d << s) | (d >> (W - s)));
      3'd5:       return (s == 0) ? d : ((d >> s) | (d << (W - s)));
      default:    return d;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] d, input int s,
                                     input logic [2:0] m);
    logic [W-1:0] r;
    r = ref_shift(d, s, m);
    if (s == 0) return 1'b0;
    case (m)
      3'd0, 3'd1: return d[W-s];
      3'd2, 3'd3: return d[s-1];
      3'd4:       return r[0];
      3'd5:       return r[W-1];
      default:    return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic         c;
  } exp_t;
  exp_t         q[$];
  logic         hold;
  logic [W-1:0] hold_d;

  // Scoreboard: sample at negedge what the next posedge will do.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_underflow", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
`ifdef SHIFTER_FLAGS_EN
          chk("sb_carry", out_carry, e.c);
          chk("sb_zero", out_zero, e.d == 0);
`endif
          n_ret++;
        end
      end
      if (in_valid && in_ready) begin
        e.d = ref_shift(in_data, int'(in_shamt), in_mode);
        e.c = ref_carry(in_data, int'(in_shamt), in_mode);
        q.push_back(e);
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an empty pipe and wait for its result.
  task automatic run_one(input logic [W-1:0] d, input logic [4:0] s, input logic [2:0] m,
                         input logic [W-1:0] exp, input string tag);
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_ovld", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_irdy", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Directed vectors
    run_one(32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, "lsl31");
    run_one(32'h8000_0000, 5'd4,  3'b011, 32'hF800_0000, "asr4");
    run_one(32'h8000_0000, 5'd4,  3'b010, 32'h0800_0000, "lsr4");
    run_one(32'h0000_00FF, 5'd8,  3'b101, 32'hFF00_0000, "ror8");
    run_one(32'h8000_0001, 5'd1,  3'b100, 32'h0000_0003, "rol1");
    run_one(32'h1234_5678, 5'd13, 3'b110, 32'h1234_5678, "rsv6");
    for (int m = 0; m < 8; m++)
      run_one(32'hDEAD_BEEF, 5'd0, 3'(m), 32'hDEAD_BEEF, "sh0");
`ifdef SHIFTER_FLAGS_EN
    run_one(32'h0000_0003, 5'd1, 3'b010, 32'h0000_0001, "f_lsr");
    chk("f_lsr_c", out_carry, 1);
    chk("f_lsr_z", out_zero, 0);
    run_one(32'h8000_0000, 5'd1, 3'b000, 32'h0000_0000, "f_lsl");
    chk("f_lsl_c", out_carry, 1);
    chk("f_lsl_z", out_zero, 1);
    run_one(32'h0000_0001, 5'd0, 3'b000, 32'h0000_0001, "f_sh0");
    chk("f_sh0_c", out_carry, 0);
`endif
    step();

    // Back-to-back stream with a 3-cycle downstream stall
    i = 0;
    base = n_ret;
    for (int c = 0; c < 25; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      if (i < 8) begin
        in_valid = 1'b1;
        in_data  = 32'h1;
        in_shamt = 5'(i);
        in_mode  = 3'b000;
      end else in_valid = 1'b0;
      #1;
      if (c >= 6 && c <= 8) chk("stall_irdy", in_ready, 0);
      if (in_valid && in_ready) i++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_issued", i, 8);
    chk("stream_retired", n_ret - base, 8);

    // Reset with three ops in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_shamt = 5'(k + 1);
      in_mode  = 3'b000;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk("mrst_ovld", out_valid, 0);
    chk("mrst_odata", out_data, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("mrst_stale", out_valid, 0);
      step();
    end
    run_one(32'h0000_00F0, 5'd4, 3'b010, 32'h0000_000F, "post_rst");
    step();

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_mode   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
